line_buffer_mt: RTL

LINE_BUFFER_MT -- requirements
Module: line_buffer_mt

---
 rtl/line_buffer_mt.sv | 126 ++++++++++++
 1 files changed

// File: rtl/line_buffer_mt.sv
// rtl/line_buffer_mt.sv - multi-tap cascaded line buffer with one shared write pointer
// Row r delays row r-1 by D pushes, so tap k presents the word pushed k*D pushes ago.
module line_buffer_mt #(
  parameter int DWIDTH    = 16,
  parameter int MAX_DEPTH = 256,
  parameter int NTAPS     = 3
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      config_en,
  input  logic [31:0]               config_addr,
  input  logic [31:0]               config_data,
  input  logic [DWIDTH-1:0]         data_in,
  input  logic                      wen_in,
  input  logic                      flush,
  output logic [NTAPS*DWIDTH-1:0]   data_out,
  output logic                      valid_out
);

  localparam int NROWS = NTAPS - 1;
  localparam int AW    = $clog2(MAX_DEPTH);
  localparam int EW    = AW + 1;
  localparam int CW    = $clog2(NROWS * MAX_DEPTH + 2);

  logic [1:0]              mode_q, mode_d;
  logic                    en_q, en_d;
  logic [12:0]             depth_q, depth_d;
  logic [AW-1:0]           wptr_q, wptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [NTAPS*DWIDTH-1:0] taps_q, taps_d;

  logic [DWIDTH-1:0] mem_q  [NROWS][MAX_DEPTH];
  logic [DWIDTH-1:0] row_rd [NROWS];
  logic [DWIDTH-1:0] row_wr [NROWS];

  logic          cfg_wr;
  logic          active;
  logic          push;
  logic [EW-1:0] depth_eff;
  logic [31:0]   thresh;
  logic          cfg_unused;

  assign cfg_unused = ^config_data[31:16];
  assign cfg_wr     = config_en && (config_addr == 32'd0);
  assign depth_eff  = (32'(depth_q) > 32'(MAX_DEPTH)) ? EW'(MAX_DEPTH) : EW'(depth_q);
  assign thresh     = 32'(NROWS) * 32'(depth_eff) + 32'd1;
  assign active     = en_q && !mode_q[1] && (depth_eff != '0);
  // Flush and config writes both take priority over a coincident push.
  assign push       = active && (mode_q[0] || wen_in) && !flush && !cfg_wr;

  always_comb begin
    for (int r = 0; r < NROWS; r++) begin
      row_rd[r] = mem_q[r][wptr_q];
    end
    row_wr[0] = data_in;
    for (int r = 1; r < NROWS; r++) begin
      row_wr[r] = row_rd[r-1];
    end
  end

  // Storage is intentionally not reset; the fill counter gates validity instead.
  always_ff @(posedge clk_in) begin
    if (push) begin
      for (int r = 0; r < NROWS; r++) begin
        mem_q[r][wptr_q] <= row_wr[r];
      end
    end
  end

  always_comb begin
    mode_d  = mode_q;
    en_d    = en_q;
    depth_d = depth_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    taps_d  = taps_q;
    if (cfg_wr) begin
      mode_d  = config_data[1:0];
      en_d    = config_data[2];
      depth_d = config_data[15:3];
      wptr_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (flush) begin
      wptr_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (push) begin
      wptr_d = ({1'b0, wptr_q} == depth_eff - 1'b1) ? '0 : wptr_q + 1'b1;
      if (32'(cnt_q) < thresh) begin
        cnt_d = cnt_q + 1'b1;
      end
      valid_d = (32'(cnt_d) >= thresh);
      taps_d[DWIDTH-1:0] = data_in;
      for (int k = 1; k < NTAPS; k++) begin
        taps_d[k*DWIDTH +: DWIDTH] = row_rd[k-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      mode_q  <= 2'b00;
      en_q    <= 1'b0;
      depth_q <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      taps_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      en_q    <= en_d;
      depth_q <= depth_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      taps_q  <= taps_d;
    end
  end

  assign data_out  = taps_q;
  assign valid_out = valid_q;

endmodule
